// File: rtl/q_row_fetch.sv
// q_row_fetch: reads one 15-action Q-table row from a single-port RAM, one
// word per cycle, and presents it in parallel on Q_Act1..Q_Act15. It also
// arbitrates single-word Q-value write-backs onto the same RAM port. Writes
// win over reads. The fetched row is published atomically at the completion
// edge.
module q_row_fetch #(
    parameter int DATA_W  = 16,
    parameter int STATE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_req,
    input  logic [STATE_W-1:0] rd_state,
    output logic               rd_ack,
    input  logic               wr_req,
    input  logic [STATE_W-1:0] wr_state,
    input  logic [3:0]         wr_action,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ack,
    output logic               busy,
    output logic               ram_en,
    output logic               ram_we,
    output logic [STATE_W+3:0] ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [DATA_W-1:0]  Q_Act1,
    output logic [DATA_W-1:0]  Q_Act2,
    output logic [DATA_W-1:0]  Q_Act3,
    output logic [DATA_W-1:0]  Q_Act4,
    output logic [DATA_W-1:0]  Q_Act5,
    output logic [DATA_W-1:0]  Q_Act6,
    output logic [DATA_W-1:0]  Q_Act7,
    output logic [DATA_W-1:0]  Q_Act8,
    output logic [DATA_W-1:0]  Q_Act9,
    output logic [DATA_W-1:0]  Q_Act10,
    output logic [DATA_W-1:0]  Q_Act11,
    output logic [DATA_W-1:0]  Q_Act12,
    output logic [DATA_W-1:0]  Q_Act13,
    output logic [DATA_W-1:0]  Q_Act14,
    output logic [DATA_W-1:0]  Q_Act15,
    output logic               q_valid
);

    localparam int         N_ACT    = 15;
    localparam logic [3:0] LAST_ACT = 4'd14;
    localparam logic [3:0] NO_SLOT  = 4'd15;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
    typedef logic [DATA_W-1:0] row_t [N_ACT];

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [STATE_W-1:0]   rd_state_q, rd_state_d;
    logic                 rd_ack_q, rd_ack_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 busy_q, busy_d;
    logic                 ram_en_q, ram_en_d;
    logic                 ram_we_q, ram_we_d;
    logic [STATE_W+3:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
    logic                 q_valid_q, q_valid_d;
    // A read issued one cycle ago has its data on ram_rdata this cycle.
    logic                 rv_q, rv_d;
    logic [3:0]           rv_idx_q, rv_idx_d;
    row_t                 shadow_q, shadow_d;
    row_t                 q_row_q, q_row_d;
    logic                 can_accept;

    // Next-state, RAM command and row-capture logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_state_d  = rd_state_q;
        rd_ack_d    = 1'b0;
        wr_ack_d    = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        q_valid_d   = q_valid_q;
        shadow_d    = shadow_q;
        q_row_d     = q_row_q;
        rv_d        = ram_en_q & ~ram_we_q;
        rv_idx_d    = ram_addr_q[3:0];
        can_accept  = 1'b0;

        if (rv_q) begin
            shadow_d[rv_idx_q] = ram_rdata;
        end

        case (state_q)
            IDLE:  can_accept = 1'b1;
            WRITE: state_d = IDLE;
            READ: begin
                if (cnt_q == LAST_ACT) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d      = cnt_q + 4'd1;
                    ram_en_d   = 1'b1;
                    ram_addr_d = {rd_state_q, cnt_d};
                end
            end
            DRAIN: begin
                // Last word lands this edge; publish the whole row at once.
                q_row_d    = shadow_d;
                q_valid_d  = 1'b1;
                state_d    = IDLE;
                can_accept = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (can_accept) begin
            if (wr_req) begin
                state_d     = WRITE;
                wr_ack_d    = 1'b1;
                ram_en_d    = (wr_action != NO_SLOT);
                ram_we_d    = (wr_action != NO_SLOT);
                ram_addr_d  = {wr_state, wr_action};
                ram_wdata_d = wr_data;
            end else if (rd_req) begin
                state_d    = READ;
                rd_ack_d   = 1'b1;
                q_valid_d  = 1'b0;
                cnt_d      = 4'd0;
                rd_state_d = rd_state;
                ram_en_d   = 1'b1;
                ram_addr_d = {rd_state, 4'd0};
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State, registered outputs and row storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_state_q  <= '0;
            rd_ack_q    <= 1'b0;
            wr_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            q_valid_q   <= 1'b0;
            rv_q        <= 1'b0;
            rv_idx_q    <= '0;
            // NOTE: the row arrays are reset because Q_Act* must read 0 out of reset; they are small flop arrays, not RAM.
            shadow_q    <= '{default: '0};
            q_row_q     <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments here so all flops update from pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_state_q  <= rd_state_d;
            rd_ack_q    <= rd_ack_d;
            wr_ack_q    <= wr_ack_d;
            busy_q      <= busy_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            q_valid_q   <= q_valid_d;
            rv_q        <= rv_d;
            rv_idx_q    <= rv_idx_d;
            shadow_q    <= shadow_d;
            q_row_q     <= q_row_d;
        end
    end

    assign rd_ack    = rd_ack_q;
    assign wr_ack    = wr_ack_q;
    assign busy      = busy_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign q_valid   = q_valid_q;

    assign Q_Act1  = q_row_q[0];
    assign Q_Act2  = q_row_q[1];
    assign Q_Act3  = q_row_q[2];
    assign Q_Act4  = q_row_q[3];
    assign Q_Act5  = q_row_q[4];
    assign Q_Act6  = q_row_q[5];
    assign Q_Act7  = q_row_q[6];
    assign Q_Act8  = q_row_q[7];
    assign Q_Act9  = q_row_q[8];
    assign Q_Act10 = q_row_q[9];
    assign Q_Act11 = q_row_q[10];
    assign Q_Act12 = q_row_q[11];
    assign Q_Act13 = q_row_q[12];
    assign Q_Act14 = q_row_q[13];
    assign Q_Act15 = q_row_q[14];

endmodule

// File: tb/tb_q_row_fetch.sv
// Directed testbench for q_row_fetch with a behavioural synchronous RAM.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_q_row_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_req, wr_req;
    logic [7:0]  rd_state, wr_state;
    logic [3:0]  wr_action;
    logic [15:0] wr_data;
    logic        rd_ack, wr_ack, busy, ram_en, ram_we, q_valid;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic [15:0] qa [15];
    logic [15:0] mem [4096];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data valid the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    q_row_fetch #(.DATA_W(16), .STATE_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_state(rd_state), .rd_ack(rd_ack),
        .wr_req(wr_req), .wr_state(wr_state), .wr_action(wr_action),
        .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .Q_Act1(qa[0]),   .Q_Act2(qa[1]),   .Q_Act3(qa[2]),   .Q_Act4(qa[3]),
        .Q_Act5(qa[4]),   .Q_Act6(qa[5]),   .Q_Act7(qa[6]),   .Q_Act8(qa[7]),
        .Q_Act9(qa[8]),   .Q_Act10(qa[9]),  .Q_Act11(qa[10]), .Q_Act12(qa[11]),
        .Q_Act13(qa[12]), .Q_Act14(qa[13]), .Q_Act15(qa[14]),
        .q_valid(q_valid)
    );

    // Wait (bounded) for a one-cycle acknowledge; returns 1 if seen.
    task automatic wait_rd_ack(output bit seen);
        int n = 0;
        do begin @(negedge clk); n++; end while (rd_ack !== 1'b1 && n < 40);
        seen = (rd_ack === 1'b1);
    endtask

    task automatic wait_wr_ack(output bit seen);
        int n = 0;
        do begin @(negedge clk); n++; end while (wr_ack !== 1'b1 && n < 40);
        seen = (wr_ack === 1'b1);
    endtask

    task automatic wait_valid(output bit seen);
        int n = 0;
        do begin @(negedge clk); n++; end while (q_valid !== 1'b1 && n < 40);
        seen = (q_valid === 1'b1);
    endtask

    // Full read of one row with request dropped after the ack.
    task automatic run_read(input logic [7:0] s, output bit ok);
        bit a, v;
        rd_req = 1'b1; rd_state = s;
        wait_rd_ack(a);
        rd_req = 1'b0;
        wait_valid(v);
        ok = a & v;
    endtask

    task automatic test_reset;
        checks++;
        if ({rd_ack, wr_ack, busy, ram_en, ram_we, q_valid} !== 6'b0 || ram_addr !== 12'h0 ||
            ram_wdata !== 16'h0 || qa[0] !== 16'h0 || qa[14] !== 16'h0) begin
            $display("FAIL reset_state ctl=%b addr=%h wdata=%h q1=%h q15=%h",
                     {rd_ack, wr_ack, busy, ram_en, ram_we, q_valid}, ram_addr, ram_wdata, qa[0], qa[14]);
            failures++;
        end
    endtask

    task automatic test_basic_read;
        bit seen;
        logic [11:0] ea;
        @(negedge clk);
        rd_req = 1'b1; rd_state = 8'd3;
        wait_rd_ack(seen);
        checks++;
        if (!seen) begin $display("FAIL basic_rd_ack got=timeout exp=pulse"); failures++; end
        rd_req = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) @(negedge clk);
            ea = 12'h030 + 12'(k);
            checks++;
            if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== ea) begin
                $display("FAIL basic_addr k=%0d en=%b we=%b addr=%h exp_addr=%h", k, ram_en, ram_we, ram_addr, ea);
                failures++;
            end
            checks++;
            if (rd_ack !== (k == 0)) begin
                $display("FAIL basic_ack_width k=%0d got=%b exp=%b", k, rd_ack, (k == 0));
                failures++;
            end
            checks++;
            if (q_valid !== 1'b0 || qa[0] !== 16'h0 || qa[14] !== 16'h0) begin
                $display("FAIL basic_mid_fetch k=%0d q_valid=%b q1=%h q15=%h exp=0", k, q_valid, qa[0], qa[14]);
                failures++;
            end
        end
        @(negedge clk);
        checks++;
        if (ram_en !== 1'b0 || busy !== 1'b1 || q_valid !== 1'b0) begin
            $display("FAIL basic_drain en=%b busy=%b q_valid=%b exp=0,1,0", ram_en, busy, q_valid);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (q_valid !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL basic_complete q_valid=%b busy=%b exp=1,0", q_valid, busy);
            failures++;
        end
        for (int a = 0; a < 15; a++) begin
            checks++;
            if (qa[a] !== 16'(a + 1)) begin
                $display("FAIL basic_row act=%0d got=%h exp=%h", a, qa[a], 16'(a + 1));
                failures++;
            end
        end
    endtask

    task automatic test_write_then_read;
        bit seen, ok;
        @(negedge clk);
        wr_req = 1'b1; wr_state = 8'd3; wr_action = 4'd2; wr_data = 16'd6;
        wait_wr_ack(seen);
        checks++;
        if (!seen || ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 12'h032 ||
            ram_wdata !== 16'd6 || busy !== 1'b1) begin
            $display("FAIL wr_cmd ack=%b en=%b we=%b addr=%h wdata=%h busy=%b", seen, ram_en, ram_we, ram_addr, ram_wdata, busy);
            failures++;
        end
        wr_req = 1'b0;
        checks++;
        if (q_valid !== 1'b1 || qa[2] !== 16'd3) begin
            $display("FAIL wr_keeps_row q_valid=%b q3=%h exp=1,0003", q_valid, qa[2]);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b0 || ram_en !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL wr_end ack=%b en=%b busy=%b exp=0,0,0", wr_ack, ram_en, busy);
            failures++;
        end
        checks++;
        if (mem[12'h032] !== 16'd6) begin
            $display("FAIL wr_mem got=%h exp=0006", mem[12'h032]);
            failures++;
        end
        run_read(8'd3, ok);
        checks++;
        if (!ok) begin $display("FAIL wr_rd_done got=timeout exp=complete"); failures++; end
        for (int a = 0; a < 15; a++) begin
            checks++;
            if (qa[a] !== ((a == 2) ? 16'd6 : 16'(a + 1))) begin
                $display("FAIL wr_rd_row act=%0d got=%h", a, qa[a]);
                failures++;
            end
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        @(negedge clk);
        wr_req = 1'b1; wr_state = 8'd3; wr_action = 4'd5; wr_data = 16'd100;
        rd_req = 1'b1; rd_state = 8'd3;
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
            $display("FAIL sim_first wr_ack=%b rd_ack=%b exp=1,0", wr_ack, rd_ack);
            failures++;
        end
        wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b0 || rd_ack !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL sim_gap wr_ack=%b rd_ack=%b busy=%b exp=0,0,0", wr_ack, rd_ack, busy);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b1 || ram_addr !== 12'h030) begin
            $display("FAIL sim_rd_ack rd_ack=%b addr=%h exp=1,030", rd_ack, ram_addr);
            failures++;
        end
        rd_req = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || qa[5] !== 16'd100 || qa[2] !== 16'd6 || qa[4] !== 16'd5) begin
            $display("FAIL sim_row done=%b q6=%h q3=%h q5=%h exp=1,0064,0006,0005", ok, qa[5], qa[2], qa[4]);
            failures++;
        end
    endtask

    task automatic test_invalid_action;
        bit seen;
        @(negedge clk);
        wr_req = 1'b1; wr_state = 8'd3; wr_action = 4'd15; wr_data = 16'hBEEF;
        wait_wr_ack(seen);
        checks++;
        if (!seen || ram_en !== 1'b0 || ram_we !== 1'b0) begin
            $display("FAIL inv_cmd ack=%b en=%b we=%b exp=1,0,0", seen, ram_en, ram_we);
            failures++;
        end
        wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b0 || ram_we !== 1'b0 || mem[12'h03F] !== 16'h0) begin
            $display("FAIL inv_effect ack=%b we=%b mem=%h exp=0,0,0000", wr_ack, ram_we, mem[12'h03F]);
            failures++;
        end
    endtask

    task automatic test_reset_mid_read;
        bit seen, ok;
        @(negedge clk);
        rd_req = 1'b1; rd_state = 8'd3;
        wait_rd_ack(seen);
        rd_req = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (!seen || ram_addr !== 12'h037) begin
            $display("FAIL rst_mid_pos ack=%b addr=%h exp=1,037", seen, ram_addr);
            failures++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_ack, wr_ack, busy, ram_en, ram_we, q_valid} !== 6'b0 || ram_addr !== 12'h0 ||
            ram_wdata !== 16'h0 || qa[0] !== 16'h0 || qa[5] !== 16'h0 || qa[14] !== 16'h0) begin
            $display("FAIL rst_async ctl=%b addr=%h wdata=%h q1=%h q6=%h",
                     {rd_ack, wr_ack, busy, ram_en, ram_we, q_valid}, ram_addr, ram_wdata, qa[0], qa[5]);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || q_valid !== 1'b0 || rd_ack !== 1'b0 || ram_en !== 1'b0) begin
            $display("FAIL rst_after busy=%b q_valid=%b rd_ack=%b en=%b exp=0", busy, q_valid, rd_ack, ram_en);
            failures++;
        end
        run_read(8'd3, ok);
        checks++;
        if (!ok) begin $display("FAIL rst_rd_done got=timeout exp=complete"); failures++; end
        for (int a = 0; a < 15; a++) begin
            checks++;
            if (qa[a] !== ((a == 2) ? 16'd6 : (a == 5) ? 16'd100 : 16'(a + 1))) begin
                $display("FAIL rst_rd_row act=%0d got=%h", a, qa[a]);
                failures++;
            end
        end
    endtask

    task automatic test_busy_blocking;
        bit seen;
        int early = 0;
        @(negedge clk);
        rd_req = 1'b1; rd_state = 8'd3;
        wait_rd_ack(seen);
        rd_req = 1'b0;
        repeat (3) @(negedge clk);
        wr_req = 1'b1; wr_state = 8'd3; wr_action = 4'd0; wr_data = 16'h0055;
        for (int k = 4; k <= 15; k++) begin
            @(negedge clk);
            if (wr_ack === 1'b1) early++;
        end
        checks++;
        if (!seen || early != 0) begin
            $display("FAIL blk_no_early rd_ack=%b early_wr_acks=%0d exp=1,0", seen, early);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b1 || q_valid !== 1'b1 || busy !== 1'b1 || qa[0] !== 16'd1 || qa[5] !== 16'd100) begin
            $display("FAIL blk_at_complete wr_ack=%b q_valid=%b busy=%b q1=%h q6=%h exp=1,1,1,0001,0064",
                     wr_ack, q_valid, busy, qa[0], qa[5]);
            failures++;
        end
        wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b0 || busy !== 1'b0 || mem[12'h030] !== 16'h0055) begin
            $display("FAIL blk_after wr_ack=%b busy=%b mem=%h exp=0,0,0055", wr_ack, busy, mem[12'h030]);
            failures++;
        end
    endtask

    task automatic test_back_to_back;
        bit seen, ok;
        @(negedge clk);
        rd_req = 1'b1; rd_state = 8'd3;
        wait_rd_ack(seen);
        repeat (15) @(negedge clk);
        checks++;
        if (!seen || rd_ack !== 1'b0 || q_valid !== 1'b0) begin
            $display("FAIL b2b_before ack_seen=%b rd_ack=%b q_valid=%b exp=1,0,0", seen, rd_ack, q_valid);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (rd_ack !== 1'b1 || q_valid !== 1'b0 || busy !== 1'b1 || ram_addr !== 12'h030 || qa[0] !== 16'h0055) begin
            $display("FAIL b2b_rd_reaccept rd_ack=%b q_valid=%b busy=%b addr=%h q1=%h exp=1,0,1,030,0055",
                     rd_ack, q_valid, busy, ram_addr, qa[0]);
            failures++;
        end
        rd_req = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || qa[0] !== 16'h0055 || qa[14] !== 16'd15) begin
            $display("FAIL b2b_rd_row done=%b q1=%h q15=%h exp=1,0055,000f", ok, qa[0], qa[14]);
            failures++;
        end
        @(negedge clk);
        wr_req = 1'b1; wr_state = 8'd4; wr_action = 4'd1; wr_data = 16'h0077;
        wait_wr_ack(seen);
        @(negedge clk);
        checks++;
        if (!seen || wr_ack !== 1'b0) begin
            $display("FAIL b2b_wr_gap first=%b wr_ack=%b exp=1,0", seen, wr_ack);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b1 || ram_addr !== 12'h041) begin
            $display("FAIL b2b_wr_second wr_ack=%b addr=%h exp=1,041", wr_ack, ram_addr);
            failures++;
        end
        wr_req = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ack !== 1'b0 || mem[12'h041] !== 16'h0077) begin
            $display("FAIL b2b_wr_end wr_ack=%b mem=%h exp=0,0077", wr_ack, mem[12'h041]);
            failures++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        for (int a = 0; a < 15; a++) mem[{8'd3, 4'(a)}] = 16'(a + 1);
        rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        rd_state = 8'd0; wr_state = 8'd0; wr_action = 4'd0; wr_data = 16'd0;
        repeat (2) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_basic_read;
        test_write_then_read;
        test_simultaneous;
        test_invalid_action;
        test_reset_mid_read;
        test_busy_blocking;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
